prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Hardware counterpart to bench-side program loading: receives a program image as a byte stream and writes it word-by-word into instruction memory.
- Holds the CPU stalled during the load, then pulses a PC reset so execution starts at address 0.
- Sits between an external byte source (UART receiver or debug port) and the instruction memory write port.
- The CPU fetch path reads what this block writes.

Parameters:
- IM_WORDS, 256, instruction memory depth in 32-bit words.
- ADDR_W, 10, width of the byte address to instruction memory (must cover 4*IM_WORDS).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- load_start  in  1  single-cycle request to begin a load
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  block accepts in_data this cycle (transfer = in_valid & in_ready)
- im_we  out  1  instruction memory write enable
- im_addr  out  ADDR_W  byte address, always word-aligned (low 2 bits 0)
- im_wdata  out  32  word to write
- cpu_hold  out  1  stall CPU (freeze PC and register/memory writes)
- pc_rst  out  1  one-cycle pulse forcing PC to 0
- done  out  1  one-cycle pulse at end of load
- err_chk  out  1  sticky: checksum mismatch on last load
- err_ovf  out  1  sticky: word count exceeded IM_WORDS on last load

Behaviour:
- Reset: state IDLE. All outputs 0: in_ready, im_we, im_addr, im_wdata, cpu_hold, pc_rst, done, err_chk, err_ovf. Internal count, word index, byte lane and checksum are cleared.
- Image format, big-endian throughout:
  - LEN_HI byte, then LEN_LO byte, giving 16-bit word count N.
  - 4*N data bytes. The first byte of each word goes to im_wdata[31:24]; the last goes to [7:0].
  - One checksum byte equal to the XOR of every preceding byte of the image, including both length bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE.
- IDLE:
  - in_ready=0, cpu_hold=0.
  - load_start=1 moves to LEN_HI, clears err_chk/err_ovf, checksum, word index and byte lane.
- cpu_hold=1 in every state except IDLE.
- in_ready=1 only in LEN_HI, LEN_LO, DATA and CHECK.
- Every accepted byte except the checksum byte is XORed into the running checksum.
- LEN_HI: on transfer, latch N[15:8], go to LEN_LO.
- LEN_LO: on transfer, latch N[7:0].
  - If N==0, go to CHECK.
  - If N>IM_WORDS, set err_ovf. The load continues regardless.
  - Otherwise go to DATA.
- DATA: on transfer, shift the byte into the word assembly register and increment the lane. When the 4th byte is accepted, go to WRITE.
- WRITE (exactly one cycle, in_ready=0):
  - im_wdata = assembled word, im_addr = 4*word_index.
  - im_we=1 only if word_index < IM_WORDS. Words beyond depth are consumed but not written.
  - word_index increments.
  - If the new index equals N, go to CHECK; otherwise go to DATA.
- Latency: 4th byte of a word accepted in cycle t gives im_we=1 in cycle t+1.
- Throughput: at most 4 bytes per 5 cycles.
- CHECK: on transfer, set err_chk if the byte differs from the running checksum. Go to DONE.
- DONE (one cycle): done=1, pc_rst=1, cpu_hold=1. Next state IDLE, where cpu_hold drops.
- Outside a WRITE cycle, im_we=0. im_addr and im_wdata hold their last values.
- load_start while not in IDLE is ignored.
- in_valid with in_ready=0 is not consumed; the source must hold the byte.
- err_chk and err_ovf stay valid until the next accepted load_start or rst.
- Reset mid-load: returns to IDLE on the next edge. cpu_hold, pc_rst and done stay 0. Words already written remain in memory. No done pulse is produced.
- rst and load_start in the same cycle: reset wins.
- N=0xFFFF: the word index must count to 65535 without wrap. Use a 16-bit index and compare against the full N.

Test Plan:
- Load N=2, words 0x20080005, 0x20090007, correct checksum → writes to addr 0 and 4 with those values. err_chk=0, err_ovf=0. done and pc_rst pulse once. cpu_hold is high from the cycle after load_start through the DONE cycle.
- Same image with the checksum byte XOR 0x01 → both words still written; err_chk=1 after DONE, cleared by the next load_start.
- N=0 (bytes 0x00, 0x00, checksum 0x00) → no im_we, done pulses, no errors.
- IM_WORDS=2, N=3 → writes only to addr 0 and 4, third word consumed without im_we, err_ovf=1, done pulses.
- in_valid toggled 1/0 every cycle during DATA → identical memory contents to the back-to-back case. No byte is lost or duplicated; in_ready=0 during each WRITE cycle.
- Assert rst after 5 data bytes of an N=2 image → first word written, state IDLE, cpu_hold=0, no done. A fresh load_start then loads correctly.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, XOR-checksummed byte image and writes it word-by-word into instruction memory while holding the CPU
module prog_loader #(
  parameter int IM_WORDS = 256,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              pc_rst,
  output logic              done,
  output logic              err_chk,
  output logic              err_ovf
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE} state_t;
  localparam logic [16:0] IMW = 17'(IM_WORDS);
  state_t state, nxt;
  logic [15:0] n, idx, n_lo;
  logic [1:0]  lane;
  logic [31:0] wbuf;
  logic [7:0]  csum;
  logic        xfer;
  assign xfer = in_valid & in_ready;
  assign n_lo = {n[15:8], in_data};
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = load_start ? LEN_HI : IDLE;
      LEN_HI:  nxt = xfer ? LEN_LO : LEN_HI;
      LEN_LO:  nxt = !xfer ? LEN_LO : (n_lo == 16'd0 ? CHECK : DATA);
      DATA:    nxt = (xfer && lane == 2'd3) ? WRITE : DATA;
      WRITE:   nxt = (idx + 16'd1 == n) ? CHECK : DATA;
      CHECK:   nxt = xfer ? DONE : CHECK;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      cpu_hold <= 1'b0;
      pc_rst   <= 1'b0;
      done     <= 1'b0;
      err_chk  <= 1'b0;
      err_ovf  <= 1'b0;
      n        <= '0;
      idx      <= '0;
      lane     <= '0;
      wbuf     <= '0;
      csum     <= '0;
    end else begin
      state    <= nxt;
      in_ready <= nxt inside {LEN_HI, LEN_LO, DATA, CHECK};
      cpu_hold <= nxt != IDLE;
      done     <= nxt == DONE;
      pc_rst   <= nxt == DONE;
      im_we    <= 1'b0;
      if (state == IDLE && load_start) begin
        err_chk <= 1'b0;
        err_ovf <= 1'b0;
        csum    <= '0;
        idx     <= '0;
        lane    <= '0;
      end
      if (xfer && state != CHECK) csum <= csum ^ in_data;
      if (xfer && state == LEN_HI) n[15:8] <= in_data;
      if (xfer && state == LEN_LO) begin
        n[7:0] <= in_data;
        if ({1'b0, n_lo} > IMW) err_ovf <= 1'b1;
      end
      if (xfer && state == DATA) begin
        wbuf <= {wbuf[23:0], in_data};
        lane <= lane + 2'd1;
        if (lane == 2'd3) begin
          im_wdata <= {wbuf[23:0], in_data};
          im_addr  <= {idx[ADDR_W-3:0], 2'b00};
          im_we    <= {1'b0, idx} < IMW;
        end
      end
      if (state == WRITE) idx <= idx + 16'd1;
      if (xfer && state == CHECK) err_chk <= in_data != csum;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader; two instances cover full depth and a 2-word memory
module tb_prog_loader;
  logic clk = 0, rst = 1, load_start = 0, in_valid = 0, sel = 0;
  logic [7:0] in_data = 0;
  logic rdy [2], we [2], hold [2], pcr [2], dn [2], ech [2], eov [2];
  logic [9:0]  addr [2];
  logic [31:0] wd [2];
  logic [41:0] wq [$];
  logic [1:0]  dq [$];
  logic [41:0] e;
  logic [1:0]  d;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  prog_loader #(.IM_WORDS(256), .ADDR_W(10)) dut0 (
    .clk(clk), .rst(rst), .load_start(load_start & ~sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .im_we(we[0]), .im_addr(addr[0]), .im_wdata(wd[0]), .cpu_hold(hold[0]),
    .pc_rst(pcr[0]), .done(dn[0]), .err_chk(ech[0]), .err_ovf(eov[0]));
  prog_loader #(.IM_WORDS(2), .ADDR_W(10)) dut1 (
    .clk(clk), .rst(rst), .load_start(load_start & sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .im_we(we[1]), .im_addr(addr[1]), .im_wdata(wd[1]), .cpu_hold(hold[1]),
    .pc_rst(pcr[1]), .done(dn[1]), .err_chk(ech[1]), .err_ovf(eov[1]));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (we[sel]) begin
        chk("write_expected", 64'(wq.size() > 0), 1);
        chk("ready_low_in_write", 64'(rdy[sel]), 0);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          chk("im_addr", 64'(addr[sel]), 64'(e[41:32]));
          chk("im_wdata", 64'(wd[sel]), 64'(e[31:0]));
        end
      end
      if (dn[sel] | pcr[sel]) begin
        chk("done_pcrst_hold", 64'({dn[sel], pcr[sel], hold[sel]}), 64'b111);
        chk("done_expected", 64'(dq.size() > 0), 1);
        if (dq.size() > 0) begin
          d = dq.pop_front();
          chk("err_flags", 64'({ech[sel], eov[sel]}), 64'(d));
        end
      end
    end
  end
  task automatic send(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) begin
      @(negedge clk);
      in_valid = 0;
    end
    @(negedge clk);
    in_valid = 1;
    in_data  = b;
    while (!rdy[sel] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 64'(rdy[sel]), 1);
    @(posedge clk);
  endtask
  task automatic start(input bit s);
    sel = s;
    @(negedge clk);
    load_start = 1;
    @(negedge clk);
    load_start = 0;
    chk("hold_after_start", 64'(hold[sel]), 1);
    chk("err_cleared", 64'({ech[sel], eov[sel]}), 0);
  endtask
  task automatic load(input bit s, input logic [15:0] n, input logic [31:0] w0, w1, w2,
                      input logic [7:0] cs, input bit gap, input int nwr, input bit ec, eo);
    logic [31:0] w [3];
    int t = 0;
    w[0] = w0; w[1] = w1; w[2] = w2;
    for (int i = 0; i < nwr; i++) wq.push_back({10'(4 * i), w[i]});
    dq.push_back({ec, eo});
    start(s);
    send(n[15:8], 0);
    send(n[7:0], 0);
    for (int i = 0; i < int'(n); i++)
      for (int b = 0; b < 4; b++) send(w[i][31-8*b -: 8], gap);
    send(cs, 0);
    @(negedge clk);
    in_valid = 0;
    while (dq.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 64'(dq.size()), 0);
    @(negedge clk);
    chk("hold_released", 64'({hold[sel], dn[sel], pcr[sel]}), 0);
    chk("writes_done", 64'(wq.size()), 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs0", 64'({rdy[0], we[0], addr[0], wd[0], hold[0], pcr[0], dn[0], ech[0], eov[0]}), 0);
    chk("reset_outs1", 64'({rdy[1], we[1], addr[1], wd[1], hold[1], pcr[1], dn[1], ech[1], eov[1]}), 0);
    rst = 0;
    load(0, 16'd2, 32'h20080005, 32'h20090007, 0, 8'h01, 0, 2, 0, 0);
    load(0, 16'd2, 32'h20080005, 32'h20090007, 0, 8'h00, 0, 2, 1, 0);
    load(0, 16'd0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    load(1, 16'd3, 32'h11223344, 32'h55667788, 32'h99aabbcc, 8'hcf, 0, 2, 0, 1);
    load(0, 16'd2, 32'h20080005, 32'h20090007, 0, 8'h01, 1, 2, 0, 0);
    wq.push_back({10'd0, 32'h20080005});
    start(0);
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h20, 0);
    send(8'h08, 0);
    send(8'h00, 0);
    send(8'h05, 0);
    send(8'h20, 0);
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_outs", 64'({hold[0], rdy[0], dn[0], pcr[0], we[0]}), 0);
    chk("rst_word0_written", 64'(wq.size()), 0);
    repeat (5) @(negedge clk);
    chk("rst_mid_idle", 64'({hold[0], rdy[0]}), 0);
    load(0, 16'd2, 32'h20080005, 32'h20090007, 0, 8'h01, 0, 2, 0, 0);
    chk("writes_left", 64'(wq.size()), 0);
    chk("dones_left", 64'(dq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
